beep_sched: RTL
===============

Name: beep_sched

Overview:
- Schedules the single board buzzer between three event sources: UART rx activity, FIR-filter frame done, and error.
- Each source gets a distinct audible pattern of 1, 2 or 3 beeps.
- Requests are latched on their rising edge, served one at a time by fixed priority, and never preempted.
- Sits between the UART/FIR control logic and the buzzer driver pin.

Parameters:
- ON_CYCLES, 27'd5000000, sys_clk cycles per beep (beep_en high); legal range 1..2^27-1.
- OFF_CYCLES, 27'd2500000, sys_clk cycles of silence between beeps and after each pattern; legal range 1..2^27-1.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  asynchronous active-low reset.
- req  input  3  request levels. Bit 0 = uart rx (1 beep), bit 1 = fir done (2 beeps), bit 2 = error (3 beeps).
- mute  input  1  forces beep_en low; sequencing timing is unchanged.
- beep_en  output  1  buzzer enable.
- grant  output  3  one-hot, identifies the source whose pattern is playing; 0 when idle.
- pending  output  3  latched, not-yet-served requests.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a pattern, including its trailing gap, completes.

Behaviour:
- Reset (sys_rst low, asynchronous): all outputs 0, req history flops 0, state IDLE, counters 0.
- Edge detect:
  - req_d registers req each cycle.
  - rise[i] = req[i] & ~req_d[i].
  - A level held high produces one request only.
- Pending:
  - rise[i] sets pending[i] at that clock edge.
  - The grant of source i clears pending[i].
  - If rise[i] and the grant of i occur in the same cycle, set wins and i is queued again.
- Arbitration:
  - Happens only in IDLE with pending != 0.
  - Highest set index wins (2 > 1 > 0).
  - grant is loaded one-hot, beeps-remaining is loaded with index+1, and the next state is ON.
- FSM states: IDLE, ON, OFF, GAP.
  - IDLE: beep_en 0, grant 0.
  - ON: beep_en = ~mute for exactly ON_CYCLES cycles. At the end, beeps-remaining decrements; if the result is 0 go to GAP, else go to OFF.
  - OFF: beep_en 0 for exactly OFF_CYCLES cycles, then ON.
  - GAP: beep_en 0 for OFF_CYCLES cycles, grant held. At the end: done=1 for one cycle, grant<=0, state IDLE.
  - IDLE with pending != 0 on the cycle after GAP starts the next pattern. There is no extra idle cycle beyond that one.
- Counter:
  - Single 27-bit phase counter, cleared on every state transition.
  - Compares against ON_CYCLES-1 / OFF_CYCLES-1; never wraps.
- Latency: with req rising sampled at edge k, pending is set after edge k, and grant and beep_en go high after edge k+1.
- No preemption: a higher-priority request arriving mid-pattern waits in pending and is served next.
- mute: affects beep_en only. grant, busy, done and timing are identical to the unmuted case. Asserting mute mid-ON silences the buzzer immediately (beep_en is combinationally gated, or registered with one-cycle latency; implementation must document which it uses, and the bench checks within 1 cycle).
- Reset mid-pattern: immediate return to reset values; pending is lost.
- Full pattern length = N*ON_CYCLES + N*OFF_CYCLES cycles in non-IDLE states, for N beeps.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2):
- Reset then req=3'b001 for one cycle -> beep_en high 4 cycles, busy 6 cycles, grant=001 for 6 cycles, done pulse at end, pending back to 0.
- req=3'b010 held high 50 cycles -> exactly one pattern: beep_en 1111 00 1111 00, no second pattern.
- req 3'b001 and 3'b100 rise in the same cycle -> grant=100 first (three 4-cycle beeps), then grant=001 one cycle after the first done.
- req[2] rises during source 0's ON phase -> source 0 completes unchanged, pending=100 meanwhile, then grant=100.
- Same source re-requested on its own grant cycle -> pending[i] stays 1 and the pattern repeats back-to-back.
- mute=1 through a 2-beep pattern -> beep_en 0 throughout, grant/busy/done timing identical; sys_rst pulsed low mid-ON -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/beep_sched.sv
// beep_sched: buzzer pattern scheduler for three event sources.
//
// Rising edges on req[2:0] are latched into pending and served one at a time.
// The highest pending index wins, and a pattern that is playing is never
// preempted. Source i plays i+1 beeps. Each beep is ON_CYCLES long. Each beep
// is followed by OFF_CYCLES of silence. After the last beep, that silence is
// the trailing gap, and done pulses once the gap has elapsed.
//
// Ports:
//   sys_clk  in   system clock
//   sys_rst  in   asynchronous active-low reset
//   req      in   [2:0] request levels (0 = uart rx, 1 = fir done, 2 = error)
//   mute     in   silences beep_en only; sequencing is unaffected
//   beep_en  out  buzzer enable
//   grant    out  [2:0] one-hot source currently playing, 0 when idle
//   pending  out  [2:0] latched requests not yet served
//   busy     out  high whenever the sequencer is not idle
//   done     out  one-cycle pulse after a pattern's trailing gap
//
// State   | meaning
// S_IDLE  | no pattern; arbitrate pending requests
// S_ON    | beep sounding for ON_CYCLES
// S_OFF   | silence between beeps for OFF_CYCLES
// S_GAP   | trailing silence after the last beep, grant still held
//
// mute is gated combinationally onto beep_en, so it acts in the same cycle.
module beep_sched #(
   parameter logic [26:0] ON_CYCLES  = 27'd5000000,
   parameter logic [26:0] OFF_CYCLES = 27'd2500000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [2:0] req,
   input  logic       mute,
   output logic       beep_en,
   output logic [2:0] grant,
   output logic [2:0] pending,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

   localparam logic [26:0] ON_LAST  = ON_CYCLES - 27'd1;
   localparam logic [26:0] OFF_LAST = OFF_CYCLES - 27'd1;

   state_t      state_q, state_d;
   logic [2:0]  req_q;
   logic [2:0]  rise;
   logic [2:0]  pending_q, pending_d;
   logic [2:0]  pend_clr;
   logic [2:0]  grant_q, grant_d;
   logic [1:0]  beeps_q, beeps_d;
   logic [26:0] cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        on_tc, off_tc;

   assign rise   = req & ~req_q;
   assign on_tc  = (cnt_q == ON_LAST);
   assign off_tc = (cnt_q == OFF_LAST);

   // state register
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|pending_q) state_d = S_ON;
         S_ON:    if (on_tc)      state_d = (beeps_q == 2'd1) ? S_GAP : S_OFF;
         S_OFF:   if (off_tc)     state_d = S_ON;
         S_GAP:   if (off_tc)     state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   // datapath next values: arbitration, beep count, phase counter, done
   always_comb begin
      grant_d  = grant_q;
      beeps_d  = beeps_q;
      pend_clr = 3'b000;
      done_d   = 1'b0;
      // Phase counter restarts on every state change and rests at 0 in idle.
      if (state_q == S_IDLE || state_d != state_q) begin
         cnt_d = 27'd0;
      end else begin
         cnt_d = cnt_q + 27'd1;
      end
      case (state_q)
         S_IDLE: begin
            if (pending_q[2]) begin
               grant_d = 3'b100;
               beeps_d = 2'd3;
            end else if (pending_q[1]) begin
               grant_d = 3'b010;
               beeps_d = 2'd2;
            end else if (pending_q[0]) begin
               grant_d = 3'b001;
               beeps_d = 2'd1;
            end
            pend_clr = grant_d & {3{|pending_q}};
         end
         S_ON: begin
            if (on_tc) beeps_d = beeps_q - 2'd1;
         end
         S_GAP: begin
            if (off_tc) begin
               done_d  = 1'b1;
               grant_d = 3'b000;
            end
         end
         default: ;
      endcase
      // A new rising edge on the same cycle as its grant re-queues the source.
      pending_d = (pending_q & ~pend_clr) | rise;
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         req_q     <= 3'b000;
         pending_q <= 3'b000;
         grant_q   <= 3'b000;
         beeps_q   <= 2'd0;
         cnt_q     <= 27'd0;
         done_q    <= 1'b0;
      end else begin
         req_q     <= req;
         pending_q <= pending_d;
         grant_q   <= grant_d;
         beeps_q   <= beeps_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
      end
   end

   // output logic
   always_comb begin
      beep_en = (state_q == S_ON) & ~mute;
      busy    = (state_q != S_IDLE);
      grant   = grant_q;
      pending = pending_q;
      done    = done_q;
   end

endmodule
